// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port: round-robin grant, registered write stage.
// Define REGFILE_WB_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [DW-1:0]        rf_wdata,
  output logic                 grant_vld,
  output logic [IW-1:0]        grant_id
);

  logic [AW-1:0] addr_arr [NREQ];
  logic [DW-1:0] data_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*AW +: AW];
      assign data_arr[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  logic [IW-1:0] winner;
  logic          found;
  logic          xfer;

`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest valid index is the last one written.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[IW'(i)]) begin
        winner = IW'(i);
        found  = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] ptr_next;
  logic [IW:0]   rr_sum;
  logic [IW-1:0] rr_idx;

  // Scan offsets from farthest to nearest so the first valid index at or after ptr wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    rr_sum = '0;
    rr_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      rr_sum = {1'b0, ptr_reg} + (IW+1)'(k);
      if (rr_sum >= (IW+1)'(NREQ)) begin
        rr_sum = rr_sum - (IW+1)'(NREQ);
      end
      rr_idx = rr_sum[IW-1:0];
      if (req_valid[rr_idx]) begin
        winner = rr_idx;
        found  = 1'b1;
      end
    end
  end

  assign ptr_next = (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (xfer) begin
      ptr_reg <= ptr_next;
    end
  end
`endif

  assign xfer      = found & ~stall & ~rst;
  assign req_ready = xfer ? (NREQ'(1) << winner) : '0;

  logic          rf_we_reg;
  logic [AW-1:0] rf_waddr_reg;
  logic [DW-1:0] rf_wdata_reg;
  logic          grant_vld_reg;
  logic [IW-1:0] grant_id_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_reg     <= 1'b0;
      rf_waddr_reg  <= '0;
      rf_wdata_reg  <= '0;
      grant_vld_reg <= 1'b0;
      grant_id_reg  <= '0;
    end else begin
      rf_we_reg     <= xfer && (addr_arr[winner] != '0);
      grant_vld_reg <= xfer;
      if (xfer) begin
        rf_waddr_reg <= addr_arr[winner];
        rf_wdata_reg <= data_arr[winner];
        grant_id_reg <= winner;
      end
    end
  end

  // A write already sitting in the output register is dropped if reset arrives in its issue cycle.
  assign rf_we     = rf_we_reg & ~rst;
  assign rf_waddr  = rf_waddr_reg;
  assign rf_wdata  = rf_wdata_reg;
  assign grant_vld = grant_vld_reg;
  assign grant_id  = grant_id_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NREQ=3, AW=5, DW=32).
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic              grant_vld;
  logic [1:0]        grant_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .grant_vld(grant_vld), .grant_id(grant_id)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2);
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0;
    set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready_with_valid got=%b exp=000", req_ready); end
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      step();
      total++; if (rf_we !== 1'b0 || grant_vld !== 1'b0) begin bad++; $display("FAIL reset_we_vld c=%0d got we=%b vld=%b exp 0/0", c, rf_we, grant_vld); end
      total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready c=%0d got=%b exp=000", c, req_ready); end
    end
    total++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || grant_id !== 2'd0) begin bad++; $display("FAIL reset_values got addr=%0d data=%h id=%0d exp 0/0/0", rf_waddr, rf_wdata, grant_id); end
    rst = 1'b0;
    step();
    total++; if (rf_we !== 1'b0 || grant_vld !== 1'b0) begin bad++; $display("FAIL idle got we=%b vld=%b exp 0/0", rf_we, grant_vld); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    set_req(3'b001, 5'd3, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0);
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL single_ready got=%b exp=001", req_ready); end
    step();
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hDEADBEEF || grant_vld !== 1'b1 || grant_id !== 2'd0) begin
      bad++; $display("FAIL single_out got we=%b addr=%0d data=%h vld=%b id=%0d exp 1/3/deadbeef/1/0", rf_we, rf_waddr, rf_wdata, grant_vld, grant_id);
    end
    step();
    total++; if (rf_we !== 1'b0 || grant_vld !== 1'b0 || rf_waddr !== 5'd3 || rf_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_hold got we=%b vld=%b addr=%0d data=%h exp 0/0/3/deadbeef", rf_we, grant_vld, rf_waddr, rf_wdata);
    end
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    set_req(3'b100, 5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'hA0);
    for (int c = 0; c < 2; c++) begin
      req_data[2*DW +: DW] = 32'hA0 + 32'(c);
      #1;
      total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL b2b_ready c=%0d got=%b exp=100", c, req_ready); end
      step();
      total++; if (rf_we !== 1'b1 || grant_id !== 2'd2 || rf_wdata !== 32'hA0 + 32'(c)) begin
        bad++; $display("FAIL b2b_out c=%0d got we=%b id=%0d data=%h exp 1/2/%h", c, rf_we, grant_id, rf_wdata, 32'hA0 + 32'(c));
      end
    end
    req_valid = '0;
    $display("test_back_to_back done");
  endtask

  task automatic test_rotation();
    logic [1:0] exp_id;
    do_reset();
    set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h101, 32'h102);
    for (int c = 0; c < 6; c++) begin
      exp_id = FIXED ? 2'd0 : 2'(c % 3);
      total++; if (req_ready !== (3'b001 << exp_id)) begin bad++; $display("FAIL rot_ready c=%0d got=%b exp=%b", c, req_ready, 3'b001 << exp_id); end
      step();
      total++; if (rf_we !== 1'b1 || grant_id !== exp_id || rf_waddr !== 5'(exp_id) + 5'd1 || rf_wdata !== 32'h100 + 32'(exp_id)) begin
        bad++; $display("FAIL rot_out c=%0d got we=%b id=%0d addr=%0d data=%h exp id=%0d", c, rf_we, grant_id, rf_waddr, rf_wdata, exp_id);
      end
    end
    req_valid = '0;
    $display("test_rotation done");
  endtask

  task automatic test_x0();
    do_reset();
    set_req(3'b011, 5'd0, 5'd7, 5'd0, 32'hAAAA, 32'hBBBB, 32'h0);
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL x0_ready1 got=%b exp=001", req_ready); end
    step();
    set_req(3'b010, 5'd0, 5'd7, 5'd0, 32'hAAAA, 32'hBBBB, 32'h0);
    total++; if (rf_we !== 1'b0 || grant_vld !== 1'b1 || grant_id !== 2'd0 || rf_waddr !== 5'd0) begin
      bad++; $display("FAIL x0_out1 got we=%b vld=%b id=%0d addr=%0d exp 0/1/0/0", rf_we, grant_vld, grant_id, rf_waddr);
    end
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL x0_ready2 got=%b exp=010", req_ready); end
    step();
    req_valid = '0;
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hBBBB || grant_id !== 2'd1) begin
      bad++; $display("FAIL x0_out2 got we=%b addr=%0d data=%h id=%0d exp 1/7/bbbb/1", rf_we, rf_waddr, rf_wdata, grant_id);
    end
    $display("test_x0 done");
  endtask

  task automatic test_stall();
    logic [2:0] exp_rdy;
    logic [1:0] exp_id;
    exp_rdy = FIXED ? 3'b001 : 3'b100;
    exp_id  = FIXED ? 2'd0 : 2'd2;
    set_req(3'b111, 5'd4, 5'd5, 5'd6, 32'h40, 32'h50, 32'h60);
    total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL stall_pre_ready got=%b exp=%b", req_ready, exp_rdy); end
    step();
    stall = 1'b1;
    #1;
    total++; if (rf_we !== 1'b1 || grant_id !== exp_id || rf_waddr !== 5'd4 + 5'(exp_id)) begin
      bad++; $display("FAIL stall_pending got we=%b id=%0d addr=%0d exp 1/%0d/%0d", rf_we, grant_id, rf_waddr, exp_id, 5'd4 + 5'(exp_id));
    end
    for (int c = 0; c < 3; c++) begin
      total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL stall_ready c=%0d got=%b exp=000", c, req_ready); end
      step();
      total++; if (rf_we !== 1'b0 || grant_vld !== 1'b0 || rf_waddr !== 5'd4 + 5'(exp_id)) begin
        bad++; $display("FAIL stall_out c=%0d got we=%b vld=%b addr=%0d exp 0/0/%0d", c, rf_we, grant_vld, rf_waddr, 5'd4 + 5'(exp_id));
      end
    end
    stall = 1'b0;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL stall_resume_ready got=%b exp=001", req_ready); end
    step();
    req_valid = '0;
    total++; if (rf_we !== 1'b1 || grant_id !== 2'd0 || rf_waddr !== 5'd4) begin
      bad++; $display("FAIL stall_resume_out got we=%b id=%0d addr=%0d exp 1/0/4", rf_we, grant_id, rf_waddr);
    end
    $display("test_stall done");
  endtask

  task automatic test_reset_mid();
    set_req(3'b010, 5'd0, 5'd9, 5'd0, 32'h0, 32'h99, 32'h0);
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL rstmid_ready got=%b exp=010", req_ready); end
    step();
    rst = 1'b1;
    set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rstmid_we_n1 got=%b exp=0", rf_we); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL rstmid_ready_in_rst got=%b exp=000", req_ready); end
    step();
    rst = 1'b0;
    #1;
    total++; if (rf_we !== 1'b0 || grant_vld !== 1'b0 || rf_waddr !== 5'd0) begin
      bad++; $display("FAIL rstmid_we_n2 got we=%b vld=%b addr=%0d exp 0/0/0", rf_we, grant_vld, rf_waddr);
    end
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL rstmid_first_grant got=%b exp=001", req_ready); end
    step();
    req_valid = '0;
    total++; if (grant_id !== 2'd0 || rf_we !== 1'b1 || rf_waddr !== 5'd1) begin
      bad++; $display("FAIL rstmid_first_out got id=%0d we=%b addr=%0d exp 0/1/1", grant_id, rf_we, rf_waddr);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_rotation();
    test_x0();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates between NREQ writeback sources (ALU, load unit, mul/div, ...) for the single write port of the 32-entry register file.
- Round-robin grant with a valid/ready handshake per requester.
- Registered output stage drives the register-file write port (we/waddr/wdata).
- Sits between the execute/memory writeback sources and the register file.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
AW, 5, register address width
DW, 32, write data width

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  reset, synchronous, active-high
stall  input  1  pipeline hold; blocks all grants this cycle
req_valid  input  NREQ  per-requester write request
req_ready  output  NREQ  per-requester grant (combinational, one-hot or zero)
req_addr  input  NREQ*AW  packed destination addresses, requester i at [i*AW +: AW]
req_data  input  NREQ*DW  packed write data, requester i at [i*DW +: DW]
rf_we  output  1  register-file write enable (registered)
rf_waddr  output  AW  register-file write address (registered)
rf_wdata  output  DW  register-file write data (registered)
grant_vld  output  1  a transfer was accepted last cycle (registered)
grant_id  output  $clog2(NREQ)  index of last accepted requester (registered)

Behaviour:
- Clocking: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, grant_vld=0, grant_id=0, round-robin pointer ptr=0.
- Arbitration (combinational): if stall=0, the winner is the first i with req_valid[i]=1 when searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - req_ready[winner]=1; all other ready bits are 0.
  - If stall=1 or no request is valid, req_ready is all zeros.
- Transfer: occurs when req_valid[i] and req_ready[i] are both high. Requesters hold valid/addr/data stable until they see ready. Ready does not depend on the data.
- Pointer update: on a transfer, ptr <= (winner+1) mod NREQ. Otherwise ptr is unchanged.
- Output stage (latency 1): in the cycle after a transfer:
  - rf_waddr and rf_wdata take the winner's addr/data.
  - grant_vld=1, grant_id=winner.
  - rf_we=1 only if the address is nonzero.
- Cycles without a transfer: rf_we=0 and grant_vld=0; rf_waddr, rf_wdata and grant_id hold their previous values.
- Address 0 writes: still granted and still advance ptr; rf_we stays 0; grant_vld=1.
- Throughput: one transfer per cycle with no bubbles. Back-to-back grants to the same requester are allowed only when it is the sole valid requester.
- Same destination from two requesters: writes are serialized in grant order, so the later grant's data ends up in the register file.
- Starvation bound: a continuously valid requester is granted within NREQ non-stalled cycles.
- stall asserted while a registered write is pending: the pending write still issues on rf_we next cycle. stall only blocks new grants.
- rst during operation: the pending registered write is discarded (rf_we=0 next cycle) and ptr returns to 0. Requests presented in the reset cycle are not granted (req_ready=0 while rst=1).

Optional Feature:
- Macro: REGFILE_WB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority arbitration; the lowest index wins and ptr is removed, with grant always the lowest valid i. All other behaviour, including x0 handling, stall and latency, is unchanged.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all req_valid=0 -> rf_we=0, grant_vld=0, req_ready=000 throughout.
- Single requester: req_valid=001, addr=5'd3, data=32'hDEADBEEF -> req_ready=001 in the same cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=DEADBEEF, grant_id=0.
- Round-robin rotation: req_valid=111 held 6 cycles -> grant order 0,1,2,0,1,2, one per cycle, with rf_we pulsing every cycle. With REGFILE_WB_ARB_FIXED_PRIO_EN defined -> requester 0 wins all 6 cycles.
- x0 write plus fairness: req0 addr=0 and req1 addr=7 both valid, ptr=0 -> cycle 1 grants req0 (rf_we=0, grant_vld=1); cycle 2 grants req1 (rf_we=1, rf_waddr=7).
- Stall: all requests valid, stall=1 for 3 cycles after one grant -> the prior write issues once, then req_ready=000 and rf_we=0 for the remaining stalled cycles. When stall drops, the next grant is from ptr.
- Reset mid-operation: transfer at cycle N with addr=9, rst=1 at cycle N+1 -> rf_we=0 at N+1 and N+2, and the first grant after reset goes to requester 0.
